// File: rtl/qsm_tx_encoder.sv
// qsm_tx_encoder: maps a 12-bit word onto a 4x2 space-modulated matrix and streams it as 8 complex samples.
// Define QSM_TX_GRAY_EN to use the Gray 16-QAM level map instead of natural binary.
module qsm_tx_encoder #(
  parameter int Q   = 22,
  parameter int N   = 32,
  parameter int AMP = 1326360
) (
  input  logic                CLOCK_50,
  input  logic                sys_rst,
  input  logic                data_valid,
  input  logic [11:0]         data_in,
  output logic                data_ready,
  output logic                x_valid,
  input  logic                x_ready,
  output logic signed [N-1:0] x_r,
  output logic signed [N-1:0] x_i,
  output logic                x_last,
  output logic                busy
);

  // AMP is only meaningful when the fractional point lies inside the sample word.
  localparam int AmpEff = (Q < N) ? AMP : 0;
  localparam logic signed [N-1:0] Lvl1 = N'(AmpEff);
  localparam logic signed [N-1:0] Lvl3 = N'(3 * AmpEff);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t               state_q;
  logic [2:0]           cnt_q;
  logic [11:0]          word_q;
  logic signed [N-1:0]  xr_q;
  logic signed [N-1:0]  xi_q;
  logic                 last_q;
  logic                 valid_q;
  logic                 accept;
  logic [2*N-1:0]       sample_d;

  function automatic logic signed [2:0] map_level(input logic [1:0] b);
    logic signed [2:0] l;
`ifdef QSM_TX_GRAY_EN
    case (b)
      2'b00:   l = -3'sd3;
      2'b01:   l = -3'sd1;
      2'b11:   l = 3'sd1;
      default: l = 3'sd3;
    endcase
`else
    case (b)
      2'b00:   l = -3'sd3;
      2'b01:   l = -3'sd1;
      2'b10:   l = 3'sd1;
      default: l = 3'sd3;
    endcase
`endif
    return l;
  endfunction

  function automatic logic signed [N-1:0] scale(input logic signed [2:0] l);
    logic signed [N-1:0] v;
    case (l)
      3'b101:  v = -Lvl3;
      3'b111:  v = -Lvl1;
      3'b001:  v = Lvl1;
      3'b011:  v = Lvl3;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Levels are kept as small signed integers through pairing and rotation; scaling happens last.
  function automatic logic [2*N-1:0] sample_at(input logic [11:0] w, input logic [2:0] n);
    logic [1:0]        ant_a;
    logic [1:0]        ant_b;
    logic signed [2:0] i1, q1, i2, q2, re, im, tmp;
    i1 = map_level(w[7:6]);
    q1 = map_level(w[5:4]);
    i2 = map_level(w[3:2]);
    q2 = map_level(w[1:0]);
    case (w[11:10])
      2'd0:    begin ant_a = 2'd0; ant_b = 2'd1; end
      2'd1:    begin ant_a = 2'd2; ant_b = 2'd3; end
      2'd2:    begin ant_a = 2'd0; ant_b = 2'd2; end
      default: begin ant_a = 2'd1; ant_b = 2'd3; end
    endcase
    re = '0;
    im = '0;
    if (n[1:0] == ant_a) begin
      re = n[2] ? -i2 : i1;
      im = n[2] ? q2 : q1;
    end else if (n[1:0] == ant_b) begin
      re = n[2] ? i1 : i2;
      im = n[2] ? -q1 : q2;
    end
    tmp = re;
    case (w[9:8])
      2'd1:    begin re = -im; im = tmp;  end
      2'd2:    begin re = -re; im = -im;  end
      2'd3:    begin re = im;  im = -tmp; end
      default: ;
    endcase
    return {scale(re), scale(im)};
  endfunction

  assign data_ready = ~sys_rst & ((state_q == IDLE) |
                                  ((state_q == EMIT) & (cnt_q == 3'd7) & x_ready));
  assign accept     = data_valid & data_ready;

  always_comb begin
    sample_d = accept ? sample_at(data_in, 3'd0) : sample_at(word_q, cnt_q + 3'd1);
  end

  // A word taken on the final beat reloads in place, keeping the stream gapless.
  always_ff @(posedge CLOCK_50 or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      xr_q    <= '0;
      xi_q    <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            word_q       <= data_in;
            cnt_q        <= '0;
            state_q      <= EMIT;
            valid_q      <= 1'b1;
            {xr_q, xi_q} <= sample_d;
            last_q       <= 1'b0;
          end
        end
        EMIT: begin
          if (x_ready) begin
            if (cnt_q == 3'd7) begin
              if (accept) begin
                word_q       <= data_in;
                cnt_q        <= '0;
                {xr_q, xi_q} <= sample_d;
                last_q       <= 1'b0;
              end else begin
                state_q <= IDLE;
                valid_q <= 1'b0;
                xr_q    <= '0;
                xi_q    <= '0;
                last_q  <= 1'b0;
              end
            end else begin
              cnt_q        <= cnt_q + 3'd1;
              {xr_q, xi_q} <= sample_d;
              last_q       <= (cnt_q == 3'd6);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign x_valid = valid_q;
  assign x_r     = xr_q;
  assign x_i     = xi_q;
  assign x_last  = last_q;
  assign busy    = (state_q == EMIT);

endmodule

// File: tb/tb_qsm_tx_encoder.sv
// tb_qsm_tx_encoder: scoreboard bench; an integer model of the matrix mapping queues expected samples per accepted word.
module tb_qsm_tx_encoder;
  localparam int N   = 32;
  localparam int AMP = 1326360;

  logic                CLOCK_50 = 1'b0;
  logic                sys_rst = 1'b1;
  logic                data_valid = 1'b0;
  logic [11:0]         data_in = 12'h000;
  logic                x_ready = 1'b0;
  logic                data_ready;
  logic                x_valid;
  logic signed [N-1:0] x_r;
  logic signed [N-1:0] x_i;
  logic                x_last;
  logic                busy;

  typedef struct {
    logic signed [N-1:0] re;
    logic signed [N-1:0] im;
    logic                last;
    int                  n;
  } exp_t;

  exp_t        expq[$];
  logic [11:0] pending[$];
  int          total = 0;
  int          bad = 0;
  int          beatNo = 0;
  bit          readyNow = 1'b1;
  bit          randReady = 1'b0;
  bit          sawAcceptOnLast = 1'b0;

  always #5 CLOCK_50 = ~CLOCK_50;

  qsm_tx_encoder dut (
    .CLOCK_50   (CLOCK_50),
    .sys_rst    (sys_rst),
    .data_valid (data_valid),
    .data_in    (data_in),
    .data_ready (data_ready),
    .x_valid    (x_valid),
    .x_ready    (x_ready),
    .x_r        (x_r),
    .x_i        (x_i),
    .x_last     (x_last),
    .busy       (busy)
  );

  function automatic int lvl(input logic [1:0] b);
    int idx;
`ifdef QSM_TX_GRAY_EN
    idx = {30'd0, b[1], b[1] ^ b[0]};
`else
    idx = {30'd0, b};
`endif
    return 2 * idx - 3;
  endfunction

  task automatic model_push(input logic [11:0] w);
    int   pa[4] = '{0, 2, 0, 1};
    int   pb[4] = '{1, 3, 2, 3};
    int   s1r, s1i, s2r, s2i, re, im, t, ant;
    exp_t e;
    s1r = lvl(w[7:6]);
    s1i = lvl(w[5:4]);
    s2r = lvl(w[3:2]);
    s2i = lvl(w[1:0]);
    for (int n = 0; n < 8; n++) begin
      ant = n % 4;
      re = 0;
      im = 0;
      if (ant == pa[w[11:10]]) begin
        if (n < 4) begin re = s1r; im = s1i; end
        else begin re = -s2r; im = s2i; end
      end else if (ant == pb[w[11:10]]) begin
        if (n < 4) begin re = s2r; im = s2i; end
        else begin re = s1r; im = -s1i; end
      end
      for (int k = 0; k < int'(w[9:8]); k++) begin
        t = re;
        re = -im;
        im = t;
      end
      e.re = re * AMP;
      e.im = im * AMP;
      e.last = (n == 7);
      e.n = n;
      expq.push_back(e);
    end
  endtask

  // One clock: drive inputs after the edge, then sample once combinational outputs settle.
  task automatic tick();
    exp_t e;
    @(posedge CLOCK_50);
    #1;
    x_ready = randReady ? 1'($urandom_range(0, 1)) : readyNow;
    data_valid = (pending.size() > 0);
    data_in = (pending.size() > 0) ? pending[0] : 12'h000;
    #1;
    if (x_valid && x_ready) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_sample got=(%0d,%0d) want=none", x_r, x_i);
      end else begin
        e = expq.pop_front();
        if (x_r !== e.re || x_i !== e.im || x_last !== e.last) begin
          bad++;
          $display("[TB] FAIL sample_n%0d got=(%0d,%0d,last=%b) want=(%0d,%0d,last=%b)",
                   e.n, x_r, x_i, x_last, e.re, e.im, e.last);
        end
      end
      beatNo = (beatNo + 1) % 8;
      if (data_valid && data_ready && x_last) sawAcceptOnLast = 1'b1;
    end
    if (data_valid && data_ready) model_push(pending.pop_front());
  endtask

  task automatic drain(input int limit);
    int c = 0;
    while ((pending.size() > 0 || expq.size() > 0) && c < limit) begin
      tick();
      c++;
    end
    total++;
    if (pending.size() > 0 || expq.size() > 0) begin
      bad++;
      $display("[TB] FAIL drain_timeout got=%0d_left want=0", pending.size() + expq.size());
      pending.delete();
      expq.delete();
    end
  endtask

  task automatic test_reset();
    #12;
    total += 6;
    if (x_valid !== 1'b0)    begin bad++; $display("[TB] FAIL rst_x_valid got=%b want=0", x_valid); end
    if (x_r !== '0)          begin bad++; $display("[TB] FAIL rst_x_r got=%0d want=0", x_r); end
    if (x_i !== '0)          begin bad++; $display("[TB] FAIL rst_x_i got=%0d want=0", x_i); end
    if (x_last !== 1'b0)     begin bad++; $display("[TB] FAIL rst_x_last got=%b want=0", x_last); end
    if (busy !== 1'b0)       begin bad++; $display("[TB] FAIL rst_busy got=%b want=0", busy); end
    if (data_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_data_ready got=%b want=0", data_ready); end
    @(negedge CLOCK_50);
    sys_rst = 1'b0;
    #1;
    total++;
    if (data_ready !== 1'b1) begin bad++; $display("[TB] FAIL idle_data_ready got=%b want=1", data_ready); end
    tick();
  endtask

  task automatic test_basic();
    readyNow = 1'b1;
    pending.push_back(12'h0B5);
    drain(40);
    tick();
    total += 3;
    if (busy !== 1'b0)       begin bad++; $display("[TB] FAIL post_busy got=%b want=0", busy); end
    if (x_valid !== 1'b0)    begin bad++; $display("[TB] FAIL post_x_valid got=%b want=0", x_valid); end
    if (data_ready !== 1'b1) begin bad++; $display("[TB] FAIL post_data_ready got=%b want=1", data_ready); end
  endtask

  task automatic test_rotation();
    pending.push_back(12'h1B5);
    pending.push_back(12'h2B5);
    pending.push_back(12'h3B5);
    drain(80);
  endtask

  task automatic test_pairs();
    pending.push_back(12'h4B5);
    pending.push_back(12'h8B5);
    pending.push_back(12'hC37);
    pending.push_back(12'hD6E);
    drain(100);
  endtask

  task automatic test_stall();
    int                  c = 0;
    logic signed [N-1:0] hr, hi;
    logic                hl;
    beatNo = 0;
    readyNow = 1'b1;
    pending.push_back(12'h0B5);
    while (beatNo != 3 && c < 20) begin tick(); c++; end
    pending.push_back(12'h5A3);
    readyNow = 1'b0;
    tick();
    hr = x_r;
    hi = x_i;
    hl = x_last;
    for (int s = 0; s < 3; s++) begin
      if (s > 0) tick();
      total++;
      if (x_r !== hr || x_i !== hi || x_last !== hl || x_valid !== 1'b1) begin
        bad++;
        $display("[TB] FAIL stall_hold got=(%0d,%0d,%b) want=(%0d,%0d,%b)", x_r, x_i, x_last, hr, hi, hl);
      end
      total++;
      if (data_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_data_ready got=%b want=0", data_ready); end
    end
    total++;
    if (pending.size() != 1) begin bad++; $display("[TB] FAIL stall_consumed got=%0d want=1", pending.size()); end
    readyNow = 1'b1;
    drain(60);
  endtask

  task automatic test_back_to_back();
    int run = 0;
    int c = 0;
    readyNow = 1'b1;
    sawAcceptOnLast = 1'b0;
    pending.push_back(12'h0B5);
    pending.push_back(12'h9C6);
    while (c < 40) begin
      tick();
      c++;
      if (x_valid) run++;
      else if (run > 0) break;
    end
    total += 2;
    if (run != 16) begin bad++; $display("[TB] FAIL b2b_run got=%0d want=16", run); end
    if (sawAcceptOnLast !== 1'b1) begin bad++; $display("[TB] FAIL b2b_accept_on_n7 got=%b want=1", sawAcceptOnLast); end
    drain(10);
  endtask

  task automatic test_reset_mid();
    int c = 0;
    beatNo = 0;
    readyNow = 1'b1;
    pending.push_back(12'h0B5);
    while (beatNo != 4 && c < 20) begin tick(); c++; end
    @(posedge CLOCK_50);
    #2;
    sys_rst = 1'b1;
    #1;
    total += 6;
    if (x_valid !== 1'b0)    begin bad++; $display("[TB] FAIL mid_x_valid got=%b want=0", x_valid); end
    if (x_r !== '0)          begin bad++; $display("[TB] FAIL mid_x_r got=%0d want=0", x_r); end
    if (x_i !== '0)          begin bad++; $display("[TB] FAIL mid_x_i got=%0d want=0", x_i); end
    if (x_last !== 1'b0)     begin bad++; $display("[TB] FAIL mid_x_last got=%b want=0", x_last); end
    if (busy !== 1'b0)       begin bad++; $display("[TB] FAIL mid_busy got=%b want=0", busy); end
    if (data_ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_data_ready got=%b want=0", data_ready); end
    expq.delete();
    beatNo = 0;
    tick();
    tick();
    @(negedge CLOCK_50);
    sys_rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      tick();
      total++;
      if (x_valid !== 1'b0) begin bad++; $display("[TB] FAIL post_rst_x_valid got=%b want=0", x_valid); end
    end
    pending.push_back(12'h0B5);
    drain(40);
  endtask

  task automatic test_random();
    randReady = 1'b1;
    for (int w = 0; w < 6; w++) pending.push_back(12'($urandom));
    drain(600);
    randReady = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rotation();
    test_pairs();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
